sq_err_window_ctrl: RTL and testbench

SQ_ERR_WINDOW_CTRL -- requirements
Module: sq_err_window_ctrl

---
 rtl/sq_err_window_ctrl.sv | 134 +++++++++++++
 tb/tb_sq_err_window_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sq_err_window_ctrl.sv
// Symbol-window controller for a squared-error accumulator: primes the pipeline, pulses clear_accum at each window boundary and captures the window sum behind a valid/ready handshake.
// Optional build macro SQ_ERR_AVG_EN replaces the raw capture with a running average (alpha = 1/4).
module sq_err_window_ctrl #(
  parameter int WIN_LEN = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clk_en_i,
  input  logic               enable_i,
  input  logic signed [38:0] sq_err_in_i,
  output logic               acc_clk_en_o,
  output logic               clear_accum_o,
  output logic signed [38:0] result_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic               overrun_o,
  output logic [15:0]        win_count_o
);

  localparam int CW = $clog2(WIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, CAPT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      sym_cnt_q, sym_cnt_d;
  logic               prime_q, prime_d;
  logic signed [38:0] result_q;
  logic signed [38:0] cap_val;
  logic               valid_q, overrun_q;
  logic [15:0]        win_cnt_q;
  logic               capt, xfer;

  always_comb begin
    state_d       = state_q;
    sym_cnt_d     = sym_cnt_q;
    prime_d       = prime_q;
    clear_accum_o = 1'b0;
    acc_clk_en_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d   = PRIME;
          sym_cnt_d = '0;
          prime_d   = 1'b0;
        end
      end
      PRIME: begin
        acc_clk_en_o = clk_en_i;
        if (!enable_i) begin
          state_d = IDLE;
        end else if (clk_en_i) begin
          // Second strobe flushes multiplier pipeline garbage; no capture follows.
          if (prime_q) begin
            clear_accum_o = 1'b1;
            state_d       = RUN;
            sym_cnt_d     = '0;
          end else begin
            prime_d = 1'b1;
          end
        end
      end
      RUN, CAPT: begin
        acc_clk_en_o = clk_en_i;
        if (!enable_i) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
          if (clk_en_i) begin
            if (sym_cnt_q == LAST) begin
              clear_accum_o = 1'b1;
              sym_cnt_d     = '0;
              state_d       = CAPT;
            end else begin
              sym_cnt_d = sym_cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The CAPT cycle always captures, even if enable has just dropped.
  assign capt = (state_q == CAPT);
  assign xfer = valid_q && result_ready_i;

`ifdef SQ_ERR_AVG_EN
  logic               avg_init_q;
  logic signed [40:0] avg_diff, avg_step, avg_sum;
  always_comb begin
    avg_diff = {{2{sq_err_in_i[38]}}, sq_err_in_i} - {{2{result_q[38]}}, result_q};
    avg_step = avg_diff >>> 2;
    avg_sum  = {{2{result_q[38]}}, result_q} + avg_step;
    cap_val  = avg_init_q ? avg_sum[38:0] : sq_err_in_i;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) avg_init_q <= 1'b0;
    else if (capt) avg_init_q <= 1'b1;
  end
`else
  assign cap_val = sq_err_in_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      prime_q   <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      prime_q   <= prime_d;
      if (capt) begin
        result_q  <= cap_val;
        valid_q   <= 1'b1;
        win_cnt_q <= win_cnt_q + 16'd1;
        if (valid_q && !result_ready_i) overrun_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign overrun_o      = overrun_q;
  assign win_count_o    = win_cnt_q;

endmodule

// File: tb/tb_sq_err_window_ctrl.sv
// Directed bench for sq_err_window_ctrl at WIN_LEN=4; expected values are hand-derived and
// switch to the averaged values when SQ_ERR_AVG_EN is defined.
module tb_sq_err_window_ctrl;

  logic               clk_i = 1'b0;
  logic               reset_i, clk_en_i, enable_i, result_ready_i;
  logic signed [38:0] sq_err_in_i;
  logic               acc_clk_en_o, clear_accum_o, result_valid_o, overrun_o;
  logic signed [38:0] result_o;
  logic [15:0]        win_count_o;

  int checks   = 0;
  int failures = 0;

`ifdef SQ_ERR_AVG_EN
  localparam logic [63:0] EXP_A2 = 64'd300;   // 400 + ((0 - 400) >>> 2)
  localparam logic [63:0] EXP_D2 = 64'd525;   // 500 + ((600 - 500) >>> 2)
`else
  localparam logic [63:0] EXP_A2 = 64'd0;
  localparam logic [63:0] EXP_D2 = 64'd600;
`endif

  sq_err_window_ctrl #(.WIN_LEN(4)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .clk_en_i       (clk_en_i),
    .enable_i       (enable_i),
    .sq_err_in_i    (sq_err_in_i),
    .acc_clk_en_o   (acc_clk_en_o),
    .clear_accum_o  (clear_accum_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .overrun_o      (overrun_o),
    .win_count_o    (win_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Advance strobes until the next clear_accum pulse; n reports the cycles taken.
  task automatic run_to_clear(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!clear_accum_o && n < 40);
    chk(tag, 64'(clear_accum_o), 64'd1);
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
  endtask

  initial begin
    int n, pulses, last_c, stray;
    reset_i = 1'b0; clk_en_i = 1'b0; enable_i = 1'b0;
    result_ready_i = 1'b0; sq_err_in_i = '0;

    // Reset state
    do_reset();
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_valid", 64'(result_valid_o), 64'd0);
    chk("rst_overrun", 64'(overrun_o), 64'd0);
    chk("rst_wincnt", 64'(win_count_o), 64'd0);

    // Continuous strobes, ready held low across two captures
    enable_i = 1'b1; clk_en_i = 1'b1;
    #1;
    chk("idle_acc_en", 64'(acc_clk_en_o), 64'd0);
    run_to_clear("prime_clear", n);
    chk("prime_cycles", 64'(n), 64'd2);
    tick();
    tick();
    chk("prime_no_capt", 64'(result_valid_o), 64'd0);
    chk("prime_acc_en", 64'(acc_clk_en_o), 64'd1);
    run_to_clear("win1_clear", n);
    chk("win1_strobes", 64'(n), 64'd2);
    tick();
    sq_err_in_i = 39'sd400;
    tick();
    chk("a_res1", 64'(result_o), 64'd400);
    chk("a_valid1", 64'(result_valid_o), 64'd1);
    chk("a_wc1", 64'(win_count_o), 64'd1);
    chk("a_ovr1", 64'(overrun_o), 64'd0);
    run_to_clear("win2_clear", n);
    chk("win2_strobes", 64'(n), 64'd2);
    tick();
    sq_err_in_i = 39'sd0;
    tick();
    chk("a_res2", 64'(result_o), EXP_A2);
    chk("a_ovr2", 64'(overrun_o), 64'd1);
    chk("a_valid2", 64'(result_valid_o), 64'd1);
    chk("a_wc2", 64'(win_count_o), 64'd2);

    // Reset in RUN with a pending result
    reset_i = 1'b0;
    tick();
    chk("b_res", 64'(result_o), 64'd0);
    chk("b_valid", 64'(result_valid_o), 64'd0);
    chk("b_ovr", 64'(overrun_o), 64'd0);
    chk("b_wc", 64'(win_count_o), 64'd0);
    chk("b_acc_en", 64'(acc_clk_en_o), 64'd0);
    chk("b_clear", 64'(clear_accum_o), 64'd0);
    reset_i = 1'b1; enable_i = 1'b0;
    tick();

    // Strobe every third cycle: pulses expected at c=6,18,30,42,54
    enable_i = 1'b1; result_ready_i = 1'b1;
    pulses = 0; last_c = 0;
    for (int c = 0; c < 60; c++) begin
      clk_en_i = (c % 3 == 0);
      #1;
      if (clear_accum_o) begin
        chk("c_pulse_en", 64'(clk_en_i), 64'd1);
        if (pulses == 0) chk("c_first", 64'(c), 64'd6);
        else chk("c_gap", 64'(c - last_c), 64'd12);
        pulses++;
        last_c = c;
      end
      tick();
    end
    chk("c_pulses", 64'(pulses), 64'd5);
    chk("c_wc", 64'(win_count_o), 64'd4);
    chk("c_ovr", 64'(overrun_o), 64'd0);

    // Capture coinciding with a transfer, then enable drop mid-window
    clk_en_i = 1'b1; result_ready_i = 1'b0; enable_i = 1'b0;
    do_reset();
    enable_i = 1'b1;
    run_to_clear("d_prime", n);
    run_to_clear("d_win1", n);
    tick();
    sq_err_in_i = 39'sd500;
    tick();
    chk("d_res1", 64'(result_o), 64'd500);
    run_to_clear("d_win2", n);
    tick();
    result_ready_i = 1'b1; sq_err_in_i = 39'sd600;
    tick();
    result_ready_i = 1'b0;
    chk("d_res2", 64'(result_o), EXP_D2);
    chk("d_valid2", 64'(result_valid_o), 64'd1);
    chk("d_ovr2", 64'(overrun_o), 64'd0);
    chk("d_wc2", 64'(win_count_o), 64'd2);
    tick();
    enable_i = 1'b0;
    #1;
    chk("d_drop_clear", 64'(clear_accum_o), 64'd0);
    tick();
    chk("d_idle_acc", 64'(acc_clk_en_o), 64'd0);
    chk("d_hold_res", 64'(result_o), EXP_D2);
    chk("d_hold_valid", 64'(result_valid_o), 64'd1);
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      if (clear_accum_o) stray++;
      tick();
    end
    chk("d_no_clear", 64'(stray), 64'd0);
    chk("d_wc_hold", 64'(win_count_o), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
